aligner_seq_ctrl: RTL and testbench

- Sequencer that sits between the compressor token stream and the byte aligner, and between the aligner and the downstream packer.
- Accepts variable-length beats over a valid/ready handshake and drives the aligner's write enable, data, length and flags.
- Inserts drain writes when the aligner reports stall, and flush writes at end of frame.
- Captures every aligned 256-bit word into a small output FIFO with valid/ready and last.

---
 rtl/aligner_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_aligner_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aligner_seq_ctrl.sv
// rtl/aligner_seq_ctrl.sv - aligner write sequencer with drain/flush insertion and output word FIFO; optional counters under ALIGNER_SEQ_CTRL_STATS_EN
module aligner_seq_ctrl #(
   parameter int DATA_IN_WIDTH  = 272,
   parameter int LEN_WIDTH      = 8,
   parameter int DATA_OUT_WIDTH = 256,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_IN_WIDTH-1:0]  s_data,
   input  logic [LEN_WIDTH-1:0]      s_len,
   input  logic [2:0]                s_flags,
   output logic                      al_wrt_en,
   output logic [DATA_IN_WIDTH-1:0]  al_data_in,
   output logic [LEN_WIDTH-1:0]      al_len,
   output logic [2:0]                al_flags_in,
   input  logic [DATA_OUT_WIDTH-1:0] al_data_out,
   input  logic [2:0]                al_flags_out,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_OUT_WIDTH-1:0] m_data,
   output logic                      m_last,
`ifdef ALIGNER_SEQ_CTRL_STATS_EN
   output logic [31:0]               stat_stall_cnt,
   output logic [31:0]               stat_frame_cnt,
   output logic [31:0]               stat_bp_cnt,
`endif
   output logic                      busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH} state_t;

   state_t                    state, state_nxt;
   logic                      pend_last;
   logic [CNT_W-1:0]          count;
   logic [PTR_W-1:0]          rd_ptr, wr_ptr;
   logic [DATA_OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic                      mem_last [FIFO_DEPTH];
   logic [15:0]               frame_words;
   logic                      push, pop, flush_cyc, tail_present, mark_tail, zero_push, do_push;
   logic [DATA_OUT_WIDTH-1:0] push_data;
   logic                      unused_tlast_out;

   assign unused_tlast_out = al_flags_out[0];

   // Aligner drive and input acceptance; nothing is accepted while reset is held.
   always_comb begin
      s_ready     = 1'b0;
      al_wrt_en   = 1'b0;
      al_data_in  = '0;
      al_len      = '0;
      al_flags_in = 3'b000;
      case (state)
         ST_RUN: begin
            s_ready = reset && (count <= CNT_W'(FIFO_DEPTH - 2));
            if (s_valid && s_ready) begin
               al_wrt_en   = 1'b1;
               al_data_in  = s_data;
               al_len      = s_len;
               al_flags_in = s_flags;
            end
         end
         ST_DRAIN: begin
            al_wrt_en   = 1'b1;
            al_flags_in = 3'b010;
         end
         ST_FLUSH: begin
            al_wrt_en   = 1'b1;
            al_flags_in = 3'b110;
         end
         default: ;
      endcase
   end

   // Next state: a stall outranks tlast; the pending tlast resurfaces after the drain.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (al_wrt_en) begin
               if (al_flags_out[1])
                  state_nxt = ST_DRAIN;
               else if (s_flags[2])
                  state_nxt = ST_FLUSH;
            end
         end
         ST_DRAIN: state_nxt = pend_last ? ST_FLUSH : ST_RUN;
         ST_FLUSH: state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // State register and tlast of the beat that caused a stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_RUN;
         pend_last <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_RUN && al_wrt_en)
            pend_last <= s_flags[2];
      end
   end

   assign pop          = m_ready && (count != '0);
   assign push         = al_wrt_en && al_flags_out[2];
   assign flush_cyc    = (state == ST_FLUSH);
   assign tail_present = (count > CNT_W'(pop));
   assign mark_tail    = flush_cyc && !push && tail_present;
   assign zero_push    = flush_cyc && !push && !tail_present;
   assign do_push      = push || zero_push;
   assign push_data    = push ? al_data_out : '0;

   // Output FIFO; an empty flush either tags the newest queued word or queues a zero last word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         frame_words <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_last[i] <= 1'b0;
         end
      end else begin
         if (do_push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= flush_cyc;
            wr_ptr           <= wr_ptr + PTR_W'(1);
            frame_words      <= flush_cyc ? 16'd0 : frame_words + 16'd1;
         end else if (mark_tail) begin
            mem_last[wr_ptr - PTR_W'(1)] <= 1'b1;
            frame_words                  <= 16'd0;
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign m_valid = (count != '0);
   assign m_data  = mem_data[rd_ptr];
   assign m_last  = m_valid && mem_last[rd_ptr];
   assign busy    = (state != ST_RUN) || (count != '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(do_push && !pop && count == CNT_W'(FIFO_DEPTH)));

`ifdef ALIGNER_SEQ_CTRL_STATS_EN
   // Saturating drain, popped-frame and backpressure counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_stall_cnt <= '0;
         stat_frame_cnt <= '0;
         stat_bp_cnt    <= '0;
      end else begin
         if (state == ST_DRAIN && stat_stall_cnt != '1)
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         if (pop && m_last && stat_frame_cnt != '1)
            stat_frame_cnt <= stat_frame_cnt + 32'd1;
         if (s_valid && !s_ready && stat_bp_cnt != '1)
            stat_bp_cnt <= stat_bp_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aligner_seq_ctrl.sv
// tb/tb_aligner_seq_ctrl.sv - directed and randomized self-checking bench for aligner_seq_ctrl with a behavioural aligner
module tb_aligner_seq_ctrl;

   logic         clk;
   logic         reset;
   logic         s_valid, s_ready;
   logic [271:0] s_data;
   logic [7:0]   s_len;
   logic [2:0]   s_flags;
   logic         al_wrt_en;
   logic [271:0] al_data_in;
   logic [7:0]   al_len;
   logic [2:0]   al_flags_in;
   logic [255:0] al_data_out;
   logic [2:0]   al_flags_out;
   logic         m_valid, m_ready, m_last, busy;
   logic [255:0] m_data;

   int n_cmp = 0;
   int n_bad = 0;
   bit rnd_ready = 0;
   bit frame_open = 0;

   logic [255:0] exp_d[$], got_d[$];
   bit           exp_l[$], got_l[$];
   byte unsigned bq[$];

   aligner_seq_ctrl dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_len(s_len), .s_flags(s_flags),
      .al_wrt_en(al_wrt_en), .al_data_in(al_data_in), .al_len(al_len), .al_flags_in(al_flags_in),
      .al_data_out(al_data_out), .al_flags_out(al_flags_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural byte aligner: packs bytes LSB-first, emits 32-byte words, stalls at 64 bytes.
   logic [511:0] acc_data, al_merged;
   int           acc_n, al_tot;

   always_comb begin
      al_merged    = acc_data | ({240'd0, al_data_in} << (8 * acc_n));
      al_tot       = acc_n + int'(al_len);
      al_data_out  = al_merged[255:0];
      al_flags_out = 3'b000;
      if (al_wrt_en) begin
         if (al_len == 8'd0)
            al_flags_out = {(al_flags_in[2] ? (acc_n > 0) : (acc_n >= 32)), 1'b0, al_flags_in[2]};
         else if (al_flags_in[0])
            al_flags_out = {(al_tot > 0), 1'b0, al_flags_in[2]};
         else
            al_flags_out = {(al_tot >= 32), (al_tot >= 64), al_flags_in[2]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_n    <= 0;
         acc_data <= '0;
      end else if (al_wrt_en) begin
         if (al_flags_out[2] && ((al_len == 8'd0 && al_flags_in[2]) || al_flags_in[0])) begin
            acc_n    <= 0;
            acc_data <= '0;
         end else if (al_flags_out[2]) begin
            acc_n    <= al_tot - 32;
            acc_data <= al_merged >> 256;
         end else begin
            acc_n    <= al_tot;
            acc_data <= al_merged;
         end
      end
   end

   always @(negedge clk) begin
      if (reset && m_valid && m_ready) begin
         got_d.push_back(m_data);
         got_l.push_back(m_last);
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: frame bytes concatenated, padded to 32 at headers and frame end, cut into words.
   task automatic model_beat(input int len, input logic [2:0] fl, input logic [271:0] d);
      for (int i = 0; i < len; i++) bq.push_back(d[8*i +: 8]);
      if (fl[0] || fl[2])
         while (bq.size() % 32 != 0) bq.push_back(8'd0);
      while (bq.size() >= 32) begin
         logic [255:0] w = '0;
         for (int i = 0; i < 32; i++) w[8*i +: 8] = bq.pop_front();
         exp_d.push_back(w);
         exp_l.push_back(1'b0);
      end
      if (fl[2]) exp_l[exp_l.size()-1] = 1'b1;
      frame_open = !fl[2];
   endtask

   task automatic step();
      @(posedge clk); #1;
      if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_beat(input int len, input logic [2:0] fl);
      logic [271:0] d = '0;
      bit acc = 0;
      for (int i = 0; i < len; i++) d[8*i +: 8] = 8'($urandom);
      s_data = d; s_len = 8'(len); s_flags = fl; s_valid = 1'b1;
      for (int k = 0; k < 300 && !acc; k++) begin
         @(negedge clk);
         acc = s_ready;
         step();
      end
      s_valid = 1'b0; s_data = '0; s_len = '0; s_flags = '0;
      if (acc) model_beat(len, fl, d);
      else chk("beat_accept", 256'(acc), 256'd1);
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 500 && (busy || m_valid); k++) step();
      chk({tag, "_idle"}, 256'(busy || m_valid), 256'd0);
   endtask

   // A frame whose tlast fell on a word boundary may end in an extra zero word carrying last.
   task automatic compare_all(input string tag);
      int j = 0;
      for (int i = 0; i < exp_d.size(); i++) begin
         if (j >= got_d.size()) begin
            chk({tag, "_short"}, 256'(got_d.size()), 256'(j + 1));
            break;
         end
         chk({tag, "_data"}, got_d[j], exp_d[i]);
         if (exp_l[i] && !got_l[j] && j + 1 < got_d.size() && got_l[j+1] && got_d[j+1] == '0)
            j++;
         else
            chk({tag, "_last"}, 256'(got_l[j]), 256'(exp_l[i]));
         j++;
      end
      chk({tag, "_count"}, 256'(got_d.size()), 256'(j));
      exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
   endtask

   initial begin
      reset = 1'b0; s_valid = 1'b0; s_data = '0; s_len = '0; s_flags = '0; m_ready = 1'b1;
      #3;
      chk("rst_s_ready", 256'(s_ready), 256'd0);
      chk("rst_wrt_en", 256'(al_wrt_en), 256'd0);
      chk("rst_m_valid", 256'(m_valid), 256'd0);
      chk("rst_m_last", 256'(m_last), 256'd0);
      chk("rst_busy", 256'(busy), 256'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("first_s_ready", 256'(s_ready), 256'd1);
      chk("idle_al_data", 256'(al_data_in), 256'd0);

      // single uncompressed word followed by flush
      send_beat(32, 3'b100);
      chk("t1_flush_s_ready", 256'(s_ready), 256'd0);
      chk("t1_flush_wrt", 256'(al_wrt_en), 256'd1);
      chk("t1_flush_flags", 256'(al_flags_in), 256'b110);
      chk("t1_flush_len", 256'(al_len), 256'd0);
      chk("t1_m_valid", 256'(m_valid), 256'd1);
      chk("t1_busy", 256'(busy), 256'd1);
      step();
      chk("t1_s_ready_back", 256'(s_ready), 256'd1);
      wait_idle("t1");

      // three compressed 20-byte beats
      send_beat(20, 3'b010); send_beat(20, 3'b010); send_beat(20, 3'b110);
      chk("t2_flush_s_ready", 256'(s_ready), 256'd0);
      step();
      chk("t2_s_ready_back", 256'(s_ready), 256'd1);
      wait_idle("t2");

      // stall on 30+34, one drain cycle
      send_beat(30, 3'b010); send_beat(34, 3'b010);
      chk("t3_drain_wrt", 256'(al_wrt_en), 256'd1);
      chk("t3_drain_len", 256'(al_len), 256'd0);
      chk("t3_drain_flags", 256'(al_flags_in), 256'b010);
      chk("t3_drain_data", 256'(al_data_in), 256'd0);
      chk("t3_drain_s_ready", 256'(s_ready), 256'd0);
      step();
      chk("t3_s_ready_back", 256'(s_ready), 256'd1);
      send_beat(10, 3'b110);
      wait_idle("t3");

      // downstream backpressure fills FIFO to 3
      m_ready = 1'b0;
      repeat (3) send_beat(32, 3'b000);
      chk("t4_full_s_ready", 256'(s_ready), 256'd0);
      chk("t4_m_valid", 256'(m_valid), 256'd1);
      m_ready = 1'b1;
      step();
      chk("t4_s_ready_back", 256'(s_ready), 256'd1);
      send_beat(32, 3'b100);
      wait_idle("t4");

      // header beat mid-frame forces a word out
      send_beat(10, 3'b010); send_beat(5, 3'b011);
      chk("t5_hdr_push", 256'(m_valid), 256'd1);
      send_beat(20, 3'b110);
      wait_idle("t5");
      compare_all("dir");

      // asynchronous reset during drain
      m_ready = 1'b0;
      send_beat(30, 3'b010); send_beat(34, 3'b010);
      chk("t6_in_drain", 256'(al_len == 8'd0 && al_wrt_en), 256'd1);
      #1 reset = 1'b0;
      #1;
      chk("t6_s_ready", 256'(s_ready), 256'd0);
      chk("t6_wrt_en", 256'(al_wrt_en), 256'd0);
      chk("t6_al_flags", 256'(al_flags_in), 256'd0);
      chk("t6_m_valid", 256'(m_valid), 256'd0);
      chk("t6_m_last", 256'(m_last), 256'd0);
      chk("t6_busy", 256'(busy), 256'd0);
      exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete(); bq.delete();
      m_ready = 1'b1;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send_beat(32, (i == 7) ? 3'b100 : 3'b000);
      wait_idle("t6");
      compare_all("rst");

      // randomized beats with random downstream readiness
      rnd_ready = 1;
      for (int n = 0; n < 200; n++) begin
         int len = $urandom_range(1, 34);
         bit hdr = ($urandom_range(0, 7) == 0);
         bit tl  = ($urandom_range(0, 5) == 0);
         bit cmp = $urandom_range(0, 1);
         if (hdr) len = $urandom_range(1, 32 - (bq.size() % 32));
         if ($urandom_range(0, 3) == 0) step();
         send_beat(len, {tl, cmp, hdr});
      end
      if (frame_open) send_beat(3, 3'b110);
      rnd_ready = 0;
      m_ready = 1'b1;
      wait_idle("rnd");
      compare_all("rnd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
